cg_iteration_controller: RTL
============================

Name: cg_iteration_controller

Overview:
- Sequences the conjugate-gradient datapath ALU across iterations.
- Launches each iteration by pulsing the ALU's vXv1/mXv1 block resets.
- Consumes the rsnew dot-product result and the end-of-iteration pulse from the ALU; compares rsnew against a tolerance and counts iterations.
- Decides continue / converged / iteration limit, and reports status to the top-level host.

Parameters:
- ELEMENT_WIDTH, 32, width of the IEEE-754 single-precision residual.
- ITER_W, 16, iteration counter width.
- MAX_ITER, 1000, iteration limit; must be >= 1 and < 2^ITER_W.
- TOLERANCE, 32'h283424DC, convergence threshold on rsnew (float32 bit pattern).
- LAUNCH_CYCLES, 2, cycles the ALU block resets are held high per launch; must be >= 1.
- WDOG_CYCLES, 65535, watchdog limit; used only with the optional feature.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- start, input, 1, single-cycle request to begin a solve.
- rsnew, input, ELEMENT_WIDTH, new residual dot product r·r from the ALU.
- rsnew_valid, input, 1, one-cycle qualifier for rsnew (the ALU's vXv3 finish).
- iter_done, input, 1, one-cycle end-of-iteration pulse (the ALU's mul_add3 finish).
- reset_vxv1, output, 1, active-high hold/reset to the ALU r·r unit.
- reset_mxv1, output, 1, active-high hold/reset to the ALU A·p unit.
- busy, output, 1, high from LAUNCH through RUN.
- done, output, 1, solve terminated; sticky.
- converged, output, 1, valid when done; 1 means rsnew <= TOLERANCE.
- bad_residual, output, 1, a latched rsnew was negative or NaN.
- timeout, output, 1, watchdog fired; constant 0 when the feature is absent.
- iter_count, output, ITER_W, number of completed iterations.
- residual, output, ELEMENT_WIDTH, last latched rsnew.

Behaviour:
- All outputs are registered.
- Reset values:
  - reset_vxv1 = 1, reset_mxv1 = 1.
  - busy, done, converged, bad_residual, timeout = 0.
  - iter_count = 0, residual = 0, internal have_rs = 0.
  - State = IDLE.
- Reset mid-operation returns to IDLE on the next edge and discards everything.
- FSM states: IDLE, LAUNCH, RUN, DONE.
- IDLE:
  - ALU resets held at 1.
  - start moves to LAUNCH; this clears iter_count, have_rs, done, converged, bad_residual and timeout.
- LAUNCH:
  - ALU resets held at 1 for exactly LAUNCH_CYCLES cycles (down-counter), then RUN.
  - Both resets drop to 0 on the first RUN cycle.
  - have_rs is cleared on entry.
- RUN:
  - On rsnew_valid: residual <= rsnew and have_rs <= 1.
  - bad_residual <= 1 if rsnew[31] = 1, or if the exponent is all ones with a nonzero mantissa.
  - On iter_done: iter_count <= iter_count + 1, then evaluate in priority order:
    1. bad_residual (including one set in the same cycle) -> DONE, converged = 0.
    2. have_rs and residual <= TOLERANCE -> DONE, converged = 1.
    3. iter_count + 1 == MAX_ITER -> DONE, converged = 0.
    4. Otherwise -> LAUNCH.
  - Comparison: both operands are non-negative floats here, so an unsigned 31-bit magnitude compare is exact.
  - rsnew_valid and iter_done in the same cycle: the incoming rsnew is used for the decision.
  - iter_done without a prior rsnew_valid this iteration: treated as not converged.
- DONE:
  - done = 1, busy = 0, ALU resets held at 1; all status is held.
  - start re-enters LAUNCH with the same clears as from IDLE.
- start is ignored while in LAUNCH or RUN.
- rsnew_valid and iter_done are ignored outside RUN.
- iter_count never wraps, because MAX_ITER < 2^ITER_W.
- Latency:
  - start -> first reset release: LAUNCH_CYCLES + 1 cycles.
  - iter_done -> next reset release: LAUNCH_CYCLES + 1 cycles.
  - iter_done -> done: 1 cycle.

Optional Feature:
- Macro: CG_ITER_WATCHDOG_EN.
- When defined:
  - A counter clears on entry to RUN and increments each RUN cycle without iter_done.
  - Reaching WDOG_CYCLES goes to DONE with timeout = 1 and converged = 0.
  - iter_done in the same cycle takes priority over the watchdog.
- When undefined: no counter; timeout is tied to 0.

Decomposition:
- Shared package cg_pkg holds:
  - FP32 field constants (sign bit, exponent and mantissa ranges).
  - The default tolerance constant CG_TOLERANCE.
  - The FSM state enumeration.
- One sub-module, fp32_le_nonneg: classifies an FP32 value as negative or NaN, and performs the magnitude <= compare against a constant.

Test Plan:
1. Reset, start, LAUNCH_CYCLES = 2 -> resets high for 2 cycles after start, low on the 3rd; busy = 1.
2. Three iterations with rsnew = 32'h3F800000 (1.0), then rsnew = 32'h28000000 with iter_done -> done = 1, converged = 1, iter_count = 4, residual = 32'h28000000.
3. MAX_ITER = 3, rsnew always 32'h3F800000 -> done after the 3rd iter_done; converged = 0, iter_count = 3.
4. rsnew = 32'hBF800000 (negative) or 32'h7FC00000 (NaN) -> bad_residual = 1; done at that iteration's iter_done; converged = 0.
5. rsnew_valid and iter_done in the same cycle with rsnew = 32'h283424DC (equal to tolerance) -> converged = 1; reset asserted mid-RUN -> all outputs at reset values on the next cycle.
6. With CG_ITER_WATCHDOG_EN and WDOG_CYCLES = 50, no iter_done -> timeout = 1 and done = 1 exactly 50 RUN cycles after release.

Source files
------------

// File: rtl/cg_pkg.sv
// Shared definitions for the conjugate-gradient iteration controller:
// FP32 field positions, the default convergence tolerance and the FSM states.
package cg_pkg;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MAN_MSB  = 22;
    localparam int FP32_MAN_LSB  = 0;

    // Default convergence threshold on r.r (float32 bit pattern, ~1.0e-14).
    localparam logic [31:0] CG_TOLERANCE = 32'h283424DC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } cg_state_t;

endpackage

// File: rtl/cg_iteration_controller_if.sv
// Controller <-> CG datapath ALU link.
// Handshake: there is no back-pressure. rsnew_valid and iter_done are
// single-cycle strobes from the ALU; rsnew is meaningful only in a cycle
// where rsnew_valid is high. reset_vxv1/reset_mxv1 are level holds from the
// controller; the ALU units run only while they are low.
interface cg_iteration_controller_if #(
    parameter int ELEMENT_WIDTH = 32
);
    logic [ELEMENT_WIDTH-1:0] rsnew;
    logic                     rsnew_valid;
    logic                     iter_done;
    logic                     reset_vxv1;
    logic                     reset_mxv1;

    // Controller side.
    modport master (
        input  rsnew, rsnew_valid, iter_done,
        output reset_vxv1, reset_mxv1
    );

    // ALU side.
    modport slave (
        output rsnew, rsnew_valid, iter_done,
        input  reset_vxv1, reset_mxv1
    );
endinterface

// File: rtl/cg_iteration_controller_fp32_le_nonneg.sv
// FP32 classifier: flags negative or NaN values, and compares the magnitude
// against a constant threshold. For two non-negative floats the unsigned
// compare of bits [30:0] orders them exactly like the float values.
module fp32_le_nonneg
    import cg_pkg::*;
#(
    parameter logic [31:0] THRESH = CG_TOLERANCE
) (
    input  logic [31:0] value,
    output logic        is_bad,
    output logic        le
);

    // Pure combinational classification and magnitude compare.
    always_comb begin
        is_bad = value[FP32_SIGN_BIT]
               | ((&value[FP32_EXP_MSB:FP32_EXP_LSB]) & (|value[FP32_MAN_MSB:FP32_MAN_LSB]));
        le     = (value[30:0] <= THRESH[30:0]);
    end

endmodule

// File: rtl/cg_iteration_controller.sv
// Conjugate-gradient iteration controller: launches each ALU iteration by
// pulsing the vXv1/mXv1 holds, latches the new residual, and decides
// continue / converged / iteration limit.
// Optional watchdog: define CG_ITER_WATCHDOG_EN to end a solve whose
// iteration never finishes within WDOG_CYCLES RUN cycles.
module cg_iteration_controller
    import cg_pkg::*;
#(
    parameter int          ELEMENT_WIDTH = 32,
    parameter int          ITER_W        = 16,
    parameter int          MAX_ITER      = 1000,
    parameter logic [31:0] TOLERANCE     = CG_TOLERANCE,
    parameter int          LAUNCH_CYCLES = 2,
    parameter int          WDOG_CYCLES   = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    cg_iteration_controller_if.master alu,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     bad_residual,
    output logic                     timeout,
    output logic [ITER_W-1:0]        iter_count,
    output logic [ELEMENT_WIDTH-1:0] residual,
    output cg_state_t                state_dbg
);

    localparam int LC_W = (LAUNCH_CYCLES > 1) ? $clog2(LAUNCH_CYCLES) : 1;

    if (MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W) || LAUNCH_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("cg_iteration_controller: illegal parameter combination");
    end

    cg_state_t                state, state_n;
    logic [LC_W-1:0]          launch_cnt;
    logic                     have_rs;
    logic [ELEMENT_WIDTH-1:0] rs_eff;
    logic                     rs_bad, rs_le;
    logic                     bad_now, have_now, conv_n, tmo_n;
    logic [ITER_W-1:0]        iter_inc;

`ifdef CG_ITER_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_cnt;
`endif

    // A residual arriving together with iter_done is the one the decision uses.
    assign rs_eff    = alu.rsnew_valid ? alu.rsnew : residual;
    assign state_dbg = state;

    fp32_le_nonneg #(.THRESH(TOLERANCE)) u_cmp (
        .value  (rs_eff),
        .is_bad (rs_bad),
        .le     (rs_le)
    );

    // Next-state and end-of-solve decision.
    always_comb begin
        state_n  = state;
        conv_n   = 1'b0;
        tmo_n    = 1'b0;
        bad_now  = bad_residual | (alu.rsnew_valid & rs_bad);
        have_now = have_rs | alu.rsnew_valid;
        iter_inc = iter_count + ITER_W'(1);
        case (state)
            ST_IDLE:   if (start) state_n = ST_LAUNCH;
            ST_LAUNCH: if (launch_cnt == '0) state_n = ST_RUN;
            ST_RUN: begin
                if (alu.iter_done) begin
                    if (bad_now) begin
                        state_n = ST_DONE;
                    end else if (have_now && rs_le) begin
                        state_n = ST_DONE;
                        conv_n  = 1'b1;
                    end else if (iter_inc == ITER_W'(MAX_ITER)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_LAUNCH;
                    end
                end
`ifdef CG_ITER_WATCHDOG_EN
                else if (wdog_cnt == WD_W'(WDOG_CYCLES - 1)) begin
                    state_n = ST_DONE;
                    tmo_n   = 1'b1;
                end
`endif
            end
            ST_DONE:   if (start) state_n = ST_LAUNCH;
            default:   state_n = ST_IDLE;
        endcase
    end

    // State register, registered outputs and per-solve status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            launch_cnt     <= '0;
            have_rs        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            converged      <= 1'b0;
            bad_residual   <= 1'b0;
            timeout        <= 1'b0;
            iter_count     <= '0;
            residual       <= '0;
            alu.reset_vxv1 <= 1'b1;
            alu.reset_mxv1 <= 1'b1;
        end else begin
            state          <= state_n;
            busy           <= (state_n == ST_LAUNCH) || (state_n == ST_RUN);
            done           <= (state_n == ST_DONE);
            alu.reset_vxv1 <= (state_n != ST_RUN);
            alu.reset_mxv1 <= (state_n != ST_RUN);

            if ((state == ST_IDLE || state == ST_DONE) && start) begin
                iter_count   <= '0;
                converged    <= 1'b0;
                bad_residual <= 1'b0;
                timeout      <= 1'b0;
            end

            if (state_n == ST_LAUNCH && state != ST_LAUNCH) begin
                launch_cnt <= LC_W'(LAUNCH_CYCLES - 1);
                have_rs    <= 1'b0;
            end else if (state == ST_LAUNCH && launch_cnt != '0) begin
                launch_cnt <= launch_cnt - LC_W'(1);
            end

            if (state == ST_RUN) begin
                if (alu.rsnew_valid) begin
                    residual <= alu.rsnew;
                    have_rs  <= 1'b1;
                    if (rs_bad) bad_residual <= 1'b1;
                end
                if (alu.iter_done) begin
                    iter_count <= iter_inc;
                    converged  <= conv_n;
                end
                if (tmo_n) timeout <= 1'b1;
            end
        end
    end

`ifdef CG_ITER_WATCHDOG_EN
    // Watchdog: cycles spent in RUN since the last launch without iter_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (state_n == ST_RUN && state != ST_RUN) begin
            wdog_cnt <= '0;
        end else if (state == ST_RUN && !alu.iter_done) begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
        end
    end
`endif

endmodule
